// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the EX stage.
// Tracks the last DEPTH post-EX instructions and selects the youngest producer per operand.
module fwd_hazard_unit #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned DEPTH     = 3,
    parameter logic [3:0]  LOAD_TYPE = 4'd2,
    parameter int unsigned LOAD_LAT  = 2,
    parameter int unsigned SEL_W     = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exValid,
    input  logic [3:0]       exInstrType,
    input  logic [REG_W-1:0] exRS,
    input  logic [REG_W-1:0] exRT,
    input  logic [REG_W-1:0] exRegDest,
    input  logic             flush,
    output logic [SEL_W-1:0] forwardRS,
    output logic [SEL_W-1:0] forwardRT,
    output logic             stall,
    output logic [CNT_W-1:0] stallCount
);

    typedef struct packed {
        logic             valid;
        logic             writes_reg;
        logic             is_load;
        logic [REG_W-1:0] dest;
    } rec_t;

    rec_t rec [1:DEPTH];
    rec_t ex_rec;

    logic [SEL_W-1:0] sel_rs;
    logic [SEL_W-1:0] sel_rt;
    logic             pend_rs;
    logic             pend_rt;
    logic             ex_uses_rs;
    logic             ex_uses_rt;
    logic             capture;

    function automatic logic dec_writes(input logic [3:0] t);
        return (t <= 4'd2) || (t >= 4'd8);
    endfunction

    function automatic logic dec_uses_rs(input logic [3:0] t);
        return !(t == 4'd4 || t == 4'd5) && !(t >= 4'd9 && t <= 4'd11);
    endfunction

    function automatic logic dec_uses_rt(input logic [3:0] t);
        return (t != 4'd1) && !(t >= 4'd4 && t <= 4'd6) && !(t >= 4'd9 && t <= 4'd11);
    endfunction

    assign ex_uses_rs = dec_uses_rs(exInstrType);
    assign ex_uses_rt = dec_uses_rt(exInstrType);

    always_comb begin
        ex_rec            = '0;
        ex_rec.valid      = 1'b1;
        ex_rec.writes_reg = dec_writes(exInstrType);
        ex_rec.is_load    = (exInstrType == LOAD_TYPE);
        ex_rec.dest       = exRegDest;
    end

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        sel_rs  = '0;
        sel_rt  = '0;
        pend_rs = 1'b0;
        pend_rt = 1'b0;
        for (int unsigned k = DEPTH; k >= 1; k--) begin
            if (exValid && ex_uses_rs && (exRS != '0) && rec[k].valid &&
                rec[k].writes_reg && (rec[k].dest == exRS)) begin
                sel_rs  = SEL_W'(k);
                pend_rs = rec[k].is_load && (k < LOAD_LAT);
            end
            if (exValid && ex_uses_rt && (exRT != '0) && rec[k].valid &&
                rec[k].writes_reg && (rec[k].dest == exRT)) begin
                sel_rt  = SEL_W'(k);
                pend_rt = rec[k].is_load && (k < LOAD_LAT);
            end
        end
    end

    // Flush and reset override everything; a stall hides both forward selects.
    assign stall     = rst_n && !flush && (pend_rs || pend_rt);
    assign forwardRS = (!rst_n || flush || stall) ? '0 : sel_rs;
    assign forwardRT = (!rst_n || flush || stall) ? '0 : sel_rt;
    assign capture   = exValid && !stall && !flush;

    // In-flight record shift register; older stages always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                rec[k] <= '0;
            end
        end else begin
            rec[1] <= capture ? ex_rec : '0;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                rec[k] <= rec[k-1];
            end
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (stall && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (CNT_W=4 so saturation is reachable).
module tb_fwd_hazard_unit;

    localparam int unsigned REG_W = 5;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             exValid;
    logic [3:0]       exInstrType;
    logic [REG_W-1:0] exRS;
    logic [REG_W-1:0] exRT;
    logic [REG_W-1:0] exRegDest;
    logic             flush;
    logic [SEL_W-1:0] forwardRS;
    logic [SEL_W-1:0] forwardRT;
    logic             stall;
    logic [CNT_W-1:0] stallCount;

    typedef struct packed {
        logic [SEL_W-1:0] frs;
        logic [SEL_W-1:0] frt;
        logic             stl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  sb_q  [$];
    string tag_q [$];
    int    checks   = 0;
    int    failures = 0;

    fwd_hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exValid     (exValid),
        .exInstrType (exInstrType),
        .exRS        (exRS),
        .exRT        (exRT),
        .exRegDest   (exRegDest),
        .flush       (flush),
        .forwardRS   (forwardRS),
        .forwardRT   (forwardRT),
        .stall       (stall),
        .stallCount  (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive EX inputs, push the expected outputs, then pop and compare after settling.
    task automatic step(input string tag, input logic v, input logic [3:0] t,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, input logic [1:0] efrs, input logic [1:0] efrt,
                        input logic est, input logic [3:0] ecnt);
        exp_t  e;
        exp_t  obs;
        string tg;
        exValid     = v;
        exInstrType = t;
        exRS        = rs;
        exRT        = rt;
        exRegDest   = rd;
        flush       = fl;
        sb_q.push_back({efrs, efrt, est, ecnt});
        tag_q.push_back(tag);
        #1;
        e   = sb_q.pop_front();
        tg  = tag_q.pop_front();
        obs = {forwardRS, forwardRT, stall, stallCount};
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed frs=%0d frt=%0d stall=%0d cnt=%0d expected frs=%0d frt=%0d stall=%0d cnt=%0d",
                   tg, obs.frs, obs.frt, obs.stl, obs.cnt, e.frs, e.frt, e.stl, e.cnt);
        end
    endtask

    task automatic nstep(input string tag, input logic v, input logic [3:0] t,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic fl, input logic [1:0] efrs, input logic [1:0] efrt,
                         input logic est, input logic [3:0] ecnt);
        @(negedge clk);
        step(tag, v, t, rs, rt, rd, fl, efrs, efrt, est, ecnt);
    endtask

    initial begin
        logic [3:0] c0;
        logic [3:0] c1;
        rst_n = 1'b0;
        @(negedge clk);
        step("reset", 1, 4'd0, 5, 5, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Producer of r5 on the first cycle after release: nothing to forward.
        step("post_rst", 1, 4'd0, 0, 0, 5, 0, 0, 0, 0, 0);
        nstep("fwd_s1",  1, 4'd0, 5, 6, 8, 0, 1, 0, 0, 0);
        nstep("fwd_s2",  1, 4'd0, 5, 6, 9, 0, 2, 0, 0, 0);
        nstep("novalid", 0, 4'd0, 9, 8, 0, 0, 0, 0, 0, 0);
        nstep("idle1",   0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        nstep("idle2",   0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use with default LOAD_LAT=2.
        nstep("ld",      1, 4'd2, 0, 0, 7, 0, 0, 0, 0, 0);
        nstep("lu_stall",1, 4'd0, 1, 7, 10, 0, 0, 0, 1, 0);
        nstep("lu_fwd",  1, 4'd0, 1, 7, 10, 0, 0, 2, 0, 1);
        // r3 in stages 1 and 3, r12 in stage 2.
        nstep("w3a",     1, 4'd0, 0, 0, 3, 0, 0, 0, 0, 1);
        nstep("wx",      1, 4'd0, 0, 0, 12, 0, 0, 0, 0, 1);
        nstep("w3b",     1, 4'd0, 0, 0, 3, 0, 0, 0, 0, 1);
        nstep("youngest",1, 4'd0, 3, 12, 0, 0, 1, 2, 0, 1);
        nstep("src_r0",  1, 4'd0, 0, 0, 13, 0, 0, 0, 0, 1);
        nstep("t3_prod", 1, 4'd3, 0, 0, 14, 0, 0, 0, 0, 1);
        nstep("t3_cons", 1, 4'd0, 14, 0, 0, 0, 0, 0, 0, 1);
        nstep("w4",      1, 4'd0, 0, 0, 4, 0, 0, 0, 0, 1);
        nstep("t10",     1, 4'd10, 4, 4, 0, 0, 0, 0, 0, 1);
        // Flush during a load-use hazard.
        nstep("ld2",     1, 4'd2, 0, 0, 7, 0, 0, 0, 0, 1);
        nstep("flush",   1, 4'd0, 7, 0, 15, 1, 0, 0, 0, 1);
        nstep("post_fl", 1, 4'd0, 7, 0, 15, 0, 2, 0, 0, 1);
        // Asynchronous reset in the middle of a stall.
        nstep("ld3",     1, 4'd2, 0, 0, 6, 0, 0, 0, 0, 1);
        nstep("stall2",  1, 4'd0, 6, 0, 0, 0, 0, 0, 1, 1);
        rst_n = 1'b0;
        step("rst_mid",  1, 4'd0, 6, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("rel2",     0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Twenty load-use stalls drive the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) begin
            c0 = (i >= 15) ? 4'd15 : 4'(i);
            c1 = (i + 1 >= 15) ? 4'd15 : 4'(i + 1);
            nstep("sat_ld",    1, 4'd2, 0, 0, 7, 0, 0, 0, 0, c0);
            nstep("sat_stall", 1, 4'd0, 0, 7, 0, 0, 0, 0, 1, c0);
            nstep("sat_fwd",   1, 4'd0, 0, 7, 0, 0, 0, 2, 0, c1);
        end
        nstep("sat_end",  0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 15);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
